fifo_burst_reader: RTL and testbench
====================================

// Module: fifo_burst_reader
// PURPOSE
//  Read-side master for async_fifo, in the rd_clk domain. On start, it pulls burst_len words through read_en/fifo_empty/data_out.
//  It absorbs the FIFO's 1-cycle read latency in a small output buffer.
//  Words leave on a valid/ready stream, and done pulses once the whole burst has been handed off.
// PARAMETERS
//  DATA_LEN   16  word width; matches async_fifo
//  LEN_W      10  burst_len width; max burst 2**LEN_W-1
//  BUF_DEPTH  3   output buffer entries; >=3 sustains 1 word/cycle
// PORTS
//  rd_clk      in   1         sole clock
//  reset       in   1         synchronous, active-high
//  start       in   1         begin burst; sampled only in IDLE
//  burst_len   in   LEN_W     words to read; captured with start
//  busy        out  1         high in RUN and DRAIN
//  done        out  1         1-cycle pulse, burst complete
//  read_en     out  1         to async_fifo read_en
//  fifo_empty  in   1         from async_fifo
//  fifo_data   in   DATA_LEN  from async_fifo data_out
//  m_data      out  DATA_LEN  stream data (buffer head)
//  m_valid     out  1         stream valid
//  m_ready     in   1         stream ready; transfer = m_valid && m_ready
//  seq_err     out  1         sequence-check flag (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, read_en=0, m_valid=0, m_data=0, seq_err=0.
//   All counters and the in-flight flag are cleared and buffered words are discarded.
//   read_en is forced 0 combinationally while reset=1.
//  FIFO read contract: fifo_data is valid exactly one rd_clk edge after an edge with read_en=1 && fifo_empty=0.
//   The in-flight flag records that such an edge has occurred.
//   The arriving word is pushed into the buffer on the following edge.
//  read_en = (state==RUN) && !fifo_empty && (issued < len_q) && (buf_cnt + inflight < BUF_DEPTH).
//   Here buf_cnt and inflight are the registered values.
//  FSM:
//   IDLE : start=1 -> capture len_q, clear issued/sent.
//          If burst_len==0 -> DONE; else -> RUN.
//   RUN  : issue reads as above. issued==len_q -> DRAIN.
//   DRAIN: no reads. sent==len_q and inflight==0 -> DONE.
//   DONE : done=1 for one cycle -> IDLE. busy=0 in DONE.
//  Counters are LEN_W bits, increment by 1, and never wrap (bounded by len_q).
//   issued increments per read_en edge; sent increments per stream transfer.
//  Buffer: FIFO ordering, head on m_data, m_valid = buf_cnt!=0.
//   Push and pop on the same edge are legal; buf_cnt is unchanged.
//   m_data/m_valid are stable while m_valid && !m_ready.
//  fifo_empty=1 mid-burst: stall issue and stay in RUN. No timeout.
//  m_ready=0 indefinitely: issue stops at BUF_DEPTH words outstanding. No overflow and no drop.
//  start while busy or in DONE: ignored.
//  reset mid-burst: immediate return to IDLE with no done pulse.
//   Words already read from the FIFO are lost; this is a caller responsibility.
// CONFIGURATION
//  Macro FIFO_BURST_READER_SEQ_CHECK_EN.
//   Defined: seq_err is set when a transfer's m_data != previous transfer's m_data + 1 (mod 2**DATA_LEN).
//    The first transfer of each burst only loads the reference.
//    seq_err is sticky until reset or an accepted start.
//   Undefined: the checker is not built and seq_err is tied 0. The port list is unchanged.
// STRUCTURE
//  New package fifo_rd_pkg:
//   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} rd_state_t
//   localparam default DATA_LEN/LEN_W
//  Sub-module rd_out_buf: parameterised DEPTH x DATA_LEN circular buffer.
//   Ports: push/din, pop/dout, count.
//   Instantiated once; the FSM and issue logic stay in fifo_burst_reader.
// TESTING
//  Setup: bench drives async_fifo with wr_clk 10ns / rd_clk 14ns, with this block on rd_clk.
//  1. Write 0..15, start len=16, m_ready=1.
//     -> m_data 0..15 in order, one done pulse, seq_err=0, fifo_empty=1 after.
//  2. start len=0.
//     -> done exactly 1 cycle after start, read_en never high, busy never high.
//  3. len=512 against a full FIFO with m_ready=1.
//     -> after the first word, one transfer per rd_clk. Data equals its index, including the pointer wrap past 511.
//  4. m_ready=0 for 20 cycles mid-burst.
//     -> read_en stops after 3 outstanding words, m_data held stable, no word lost or duplicated on release.
//  5. FIFO holds 4 words, len=8, remaining 4 written 30 cycles later.
//     -> stays in RUN with read_en=0 while empty; completes with done and all 8 words.
//  6. reset asserted while busy.
//     -> next edge: busy=0, m_valid=0, read_en=0, no done. A following start len=2 reads the next two FIFO words.
//  With the macro defined: inject 5,6,8.
//     -> seq_err=1 on the word 8 transfer, held until the next start.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : fifo_rd_pkg
//  Description : Shared types and default widths for the FIFO burst reader.
//                rd_state_t : reader FSM state encoding
//                DATA_LEN_DEF / LEN_W_DEF : default word and length widths
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_t;

  localparam int DATA_LEN_DEF = 16;
  localparam int LEN_W_DEF    = 10;

endpackage : fifo_rd_pkg
`default_nettype wire

// File: rtl/rd_out_buf.sv
`default_nettype none
// ============================================================================
//  Module      : rd_out_buf
//  Description : DEPTH x DATA_LEN circular buffer holding words returned by
//                the FIFO until the stream sink accepts them.
//  Ports       : clk_i   - clock
//                reset_i - synchronous active-high reset (empties buffer)
//                push_i  - write din_i at the tail
//                din_i   - incoming word
//                pop_i   - drop the head word (ignored when empty)
//                dout_o  - head word, 0 while empty
//                count_o - number of stored words
//  Revision    : 1.0 - initial release
// ============================================================================
module rd_out_buf #(
  parameter int DEPTH    = 3,
  parameter int DATA_LEN = 16,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                push_i,
  input  logic [DATA_LEN-1:0] din_i,
  input  logic                pop_i,
  output logic [DATA_LEN-1:0] dout_o,
  output logic [CNT_W-1:0]    count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_LEN-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q;
  logic [PTR_W-1:0]    rd_ptr_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                do_pop;
  logic                do_push;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop_i && (cnt_q != '0);
  // A push into a full buffer is only accepted when the head leaves on the same edge.
  assign do_push = push_i && ((cnt_q != CNT_W'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign count_o = cnt_q;

endmodule : rd_out_buf
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Read-side master for async_fifo. On start it pulls
//                burst_len words from the FIFO (1-cycle read latency), holds
//                them in a small buffer and hands them off on a valid/ready
//                stream. done pulses once the whole burst has been accepted.
//  Ports       : rd_clk_i      - clock
//                reset_i       - synchronous active-high reset
//                start_i       - begin burst (sampled in IDLE only)
//                burst_len_i   - words to read, captured with start
//                busy_o        - high in RUN and DRAIN
//                done_o        - one-cycle completion pulse
//                read_en_o     - FIFO read request
//                fifo_empty_i  - FIFO empty flag
//                fifo_data_i   - FIFO read data
//                m_data_o      - stream data (buffer head)
//                m_valid_o     - stream valid
//                m_ready_i     - stream ready
//                seq_err_o     - sequence-check flag
//  Macro       : FIFO_BURST_READER_SEQ_CHECK_EN builds the +1 sequence
//                checker; otherwise seq_err_o is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_LEN  = DATA_LEN_DEF,
  parameter int LEN_W     = LEN_W_DEF,
  parameter int BUF_DEPTH = 3
) (
  input  logic                rd_clk_i,
  input  logic                reset_i,
  input  logic                start_i,
  input  logic [LEN_W-1:0]    burst_len_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                read_en_o,
  input  logic                fifo_empty_i,
  input  logic [DATA_LEN-1:0] fifo_data_i,
  output logic [DATA_LEN-1:0] m_data_o,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic                seq_err_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  rd_state_t        state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] sent_q;
  logic             inflight_q;
  logic             busy_q;
  logic             done_q;

  logic [CNT_W-1:0] buf_cnt;
  logic             read_en;
  logic             xfer;
  logic             start_ok;

  // Outstanding words (buffered plus the one on the FIFO data bus) never
  // exceed the buffer depth, so a stalled sink can never cause an overflow.
  assign read_en = !reset_i && (state_q == RUN) && !fifo_empty_i &&
                   (issued_q < len_q) &&
                   ((int'(buf_cnt) + int'(inflight_q)) < BUF_DEPTH);

  assign m_valid_o = (buf_cnt != '0);
  assign xfer      = m_valid_o && m_ready_i;
  assign start_ok  = (state_q == IDLE) && start_i;

  // The word requested on the previous edge is on fifo_data_i now.
  rd_out_buf #(
    .DEPTH    (BUF_DEPTH),
    .DATA_LEN (DATA_LEN),
    .CNT_W    (CNT_W)
  ) u_out_buf (
    .clk_i   (rd_clk_i),
    .reset_i (reset_i),
    .push_i  (inflight_q),
    .din_i   (fifo_data_i),
    .pop_i   (xfer),
    .dout_o  (m_data_o),
    .count_o (buf_cnt)
  );

  always_ff @(posedge rd_clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      inflight_q <= read_en;
      if (xfer && (sent_q < len_q)) sent_q <= sent_q + LEN_W'(1);
      case (state_q)
        IDLE: begin
          if (start_i) begin
            len_q    <= burst_len_i;
            issued_q <= '0;
            sent_q   <= '0;
            if (burst_len_i == '0) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RUN;
              busy_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (read_en) issued_q <= issued_q + LEN_W'(1);
          if (issued_q == len_q) state_q <= DRAIN;
        end
        DRAIN: begin
          if ((sent_q == len_q) && !inflight_q) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign read_en_o = read_en;

`ifdef FIFO_BURST_READER_SEQ_CHECK_EN
  logic [DATA_LEN-1:0] seq_ref_q;
  logic                seq_have_q;
  logic                seq_err_q;

  // The first transfer of a burst only seeds the reference value.
  always_ff @(posedge rd_clk_i) begin
    if (reset_i) begin
      seq_ref_q  <= '0;
      seq_have_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (start_ok) begin
      seq_have_q <= 1'b0;
      seq_err_q  <= 1'b0;
    end else if (xfer) begin
      if (seq_have_q && (m_data_o != seq_ref_q + DATA_LEN'(1))) seq_err_q <= 1'b1;
      seq_ref_q  <= m_data_o;
      seq_have_q <= 1'b1;
    end
  end

  assign seq_err_o = seq_err_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign seq_err_o       = 1'b0;
`endif

endmodule : fifo_burst_reader
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_burst_reader
//  Description : Bench for fifo_burst_reader with a behavioural 1-cycle
//                latency FIFO and a scoreboard on the output stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

  localparam int DATA_LEN  = 16;
  localparam int LEN_W     = 10;
  localparam int BUF_DEPTH = 3;

  logic                rd_clk = 1'b0;
  logic                reset;
  logic                start;
  logic [LEN_W-1:0]    burst_len;
  logic                busy;
  logic                done;
  logic                read_en;
  logic                fifo_empty;
  logic [DATA_LEN-1:0] fifo_data;
  logic [DATA_LEN-1:0] m_data;
  logic                m_valid;
  logic                m_ready;
  logic                seq_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_LEN-1:0] mem   [$];
  logic [DATA_LEN-1:0] exp_q [$];

  int cyc       = 0;
  int rd_cnt    = 0;
  int xfer_cnt  = 0;
  int done_cnt  = 0;
  int rden_cnt  = 0;
  int busy_cnt  = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  bit                  hold_pend = 0;
  logic [DATA_LEN-1:0] hold_data;

  always #7 rd_clk = ~rd_clk;

  fifo_burst_reader #(
    .DATA_LEN  (DATA_LEN),
    .LEN_W     (LEN_W),
    .BUF_DEPTH (BUF_DEPTH)
  ) dut (
    .rd_clk_i     (rd_clk),
    .reset_i      (reset),
    .start_i      (start),
    .burst_len_i  (burst_len),
    .busy_o       (busy),
    .done_o       (done),
    .read_en_o    (read_en),
    .fifo_empty_i (fifo_empty),
    .fifo_data_i  (fifo_data),
    .m_data_o     (m_data),
    .m_valid_o    (m_valid),
    .m_ready_i    (m_ready),
    .seq_err_o    (seq_err)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // FIFO model: data appears one edge after an accepted read.
  initial begin
    fifo_empty = 1'b1;
    fifo_data  = '0;
  end

  always @(posedge rd_clk) begin
    if (read_en) begin
      if (mem.size() == 0) begin
        n_fail++;
        $display("FAIL fifo_underrun: read_en=1 with empty FIFO at cycle %0d", cyc);
      end else begin
        fifo_data <= mem.pop_front();
        rd_cnt++;
      end
    end
    fifo_empty <= (mem.size() == 0);
  end

  task automatic fifo_write(input logic [DATA_LEN-1:0] v);
    mem.push_back(v);
    fifo_empty = 1'b0;
  endtask

  // Monitor: samples on the falling edge, i.e. what the next rising edge will see.
  always @(negedge rd_clk) begin
    if (!reset) begin
      if (m_valid && m_ready) begin
        xfer_cnt++;
        if (xfer_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_word: got %0d expected no transfer", m_data);
        end else begin
          check("m_data", {16'd0, m_data}, {16'd0, exp_q.pop_front()});
        end
      end
      if (hold_pend) begin
        check("hold_valid", {31'd0, m_valid}, 32'd1);
        check("hold_data", {16'd0, m_data}, {16'd0, hold_data});
      end
      hold_pend = m_valid && !m_ready;
      hold_data = m_data;
      if (done)    done_cnt++;
      if (read_en) rden_cnt++;
      if (busy)    busy_cnt++;
    end else begin
      hold_pend = 0;
    end
    cyc++;
  end

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic do_start(input int len);
    burst_len = LEN_W'(len);
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string nm);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge rd_clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_done_timeout: no done within %0d cycles, required done=1", nm, budget);
    end
    tick();
  endtask

  task automatic wait_xfer(input int n, input int budget, input string nm);
    bit seen = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge rd_clk);
      if (xfer_cnt >= n) begin
        seen = 1;
        break;
      end
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s_xfer_timeout: got %0d transfers required %0d", nm, xfer_cnt, n);
    end
    tick();
  endtask

  initial begin
    #(14 * 30000);
    $display("FAIL watchdog: simulation time limit reached, required test completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, r0, b0;
    logic [DATA_LEN-1:0] e0, e1;

    reset     = 1'b1;
    start     = 1'b0;
    burst_len = '0;
    m_ready   = 1'b1;
    repeat (3) @(posedge rd_clk);
    @(negedge rd_clk);
    check("rst_busy",    {31'd0, busy},    32'd0);
    check("rst_done",    {31'd0, done},    32'd0);
    check("rst_read_en", {31'd0, read_en}, 32'd0);
    check("rst_m_valid", {31'd0, m_valid}, 32'd0);
    check("rst_m_data",  {16'd0, m_data},  32'd0);
    check("rst_seq_err", {31'd0, seq_err}, 32'd0);
    tick();
    reset = 1'b0;
    tick();

    // 1: sixteen sequential words
    for (int i = 0; i < 16; i++) begin
      fifo_write(DATA_LEN'(i));
      exp_q.push_back(DATA_LEN'(i));
    end
    d0 = done_cnt;
    do_start(16);
    wait_done(200, "t1");
    repeat (3) tick();
    check("t1_done_pulses", done_cnt - d0, 32'd1);
    check("t1_all_words",   exp_q.size(), 32'd0);
    check("t1_seq_err",     {31'd0, seq_err}, 32'd0);
    check("t1_fifo_empty",  {31'd0, fifo_empty}, 32'd1);

    // 2: zero-length burst
    d0 = done_cnt; r0 = rden_cnt; b0 = busy_cnt;
    burst_len = '0;
    start     = 1'b1;
    @(negedge rd_clk);
    check("t2_done_before", {31'd0, done}, 32'd0);
    @(posedge rd_clk); #2;
    start = 1'b0;
    @(negedge rd_clk);
    check("t2_done_after1", {31'd0, done}, 32'd1);
    @(negedge rd_clk);
    check("t2_done_after2", {31'd0, done}, 32'd0);
    repeat (3) tick();
    check("t2_read_en_cnt", rden_cnt - r0, 32'd0);
    check("t2_busy_cnt",    busy_cnt - b0, 32'd0);
    check("t2_done_pulses", done_cnt - d0, 32'd1);

    // 3: 512 words at full rate
    for (int i = 0; i < 512; i++) begin
      fifo_write(DATA_LEN'(i));
      exp_q.push_back(DATA_LEN'(i));
    end
    xfer_cnt = 0;
    do_start(512);
    wait_done(2000, "t3");
    check("t3_xfer_cnt",   xfer_cnt, 32'd512);
    check("t3_throughput", last_cyc - first_cyc, 32'd511);
    check("t3_all_words",  exp_q.size(), 32'd0);

    // 4: sink stalls for 20 cycles mid-burst
    for (int i = 0; i < 12; i++) begin
      fifo_write(DATA_LEN'(1000 + i));
      exp_q.push_back(DATA_LEN'(1000 + i));
    end
    xfer_cnt = 0; rd_cnt = 0;
    do_start(12);
    wait_xfer(3, 50, "t4");
    m_ready = 1'b0;
    repeat (20) tick();
    check("t4_outstanding", rd_cnt - xfer_cnt, 32'd3);
    check("t4_read_en_off", {31'd0, read_en}, 32'd0);
    check("t4_stall_valid", {31'd0, m_valid}, 32'd1);
    m_ready = 1'b1;
    wait_done(200, "t4");
    check("t4_xfer_cnt",  xfer_cnt, 32'd12);
    check("t4_rd_cnt",    rd_cnt, 32'd12);
    check("t4_all_words", exp_q.size(), 32'd0);

    // 5: FIFO runs dry mid-burst
    for (int i = 0; i < 8; i++) exp_q.push_back(DATA_LEN'(200 + i));
    for (int i = 0; i < 4; i++) fifo_write(DATA_LEN'(200 + i));
    xfer_cnt = 0;
    do_start(8);
    repeat (30) tick();
    check("t5_busy_stall",    {31'd0, busy}, 32'd1);
    check("t5_read_en_stall", {31'd0, read_en}, 32'd0);
    check("t5_xfer_partial",  xfer_cnt, 32'd4);
    for (int i = 4; i < 8; i++) fifo_write(DATA_LEN'(200 + i));
    wait_done(200, "t5");
    check("t5_all_words", exp_q.size(), 32'd0);

    // 6: reset during a burst
    for (int i = 0; i < 10; i++) begin
      fifo_write(DATA_LEN'(300 + i));
      exp_q.push_back(DATA_LEN'(300 + i));
    end
    xfer_cnt = 0;
    do_start(10);
    wait_xfer(2, 50, "t6");
    d0 = done_cnt;
    reset = 1'b1;
    @(posedge rd_clk);
    @(negedge rd_clk);
    check("t6_busy",    {31'd0, busy},    32'd0);
    check("t6_m_valid", {31'd0, m_valid}, 32'd0);
    check("t6_read_en", {31'd0, read_en}, 32'd0);
    check("t6_done",    {31'd0, done},    32'd0);
    tick();
    reset = 1'b0;
    exp_q.delete();
    e0 = mem[0];
    e1 = mem[1];
    exp_q.push_back(e0);
    exp_q.push_back(e1);
    tick();
    do_start(2);
    wait_done(100, "t6");
    check("t6_done_pulses", done_cnt - d0, 32'd1);
    check("t6_all_words",   exp_q.size(), 32'd0);
    mem.delete();
    fifo_empty = 1'b1;
    tick();

`ifdef FIFO_BURST_READER_SEQ_CHECK_EN
    // 7: broken sequence 5,6,8
    fifo_write(16'd5); fifo_write(16'd6); fifo_write(16'd8);
    exp_q.push_back(16'd5); exp_q.push_back(16'd6); exp_q.push_back(16'd8);
    do_start(3);
    wait_done(100, "t7");
    check("t7_seq_err_set", {31'd0, seq_err}, 32'd1);
    repeat (5) tick();
    check("t7_seq_err_held", {31'd0, seq_err}, 32'd1);
    fifo_write(16'd9);
    exp_q.push_back(16'd9);
    do_start(1);
    check("t7_seq_err_clr", {31'd0, seq_err}, 32'd0);
    wait_done(100, "t7b");
    check("t7_all_words", exp_q.size(), 32'd0);
`else
    check("seq_err_tied", {31'd0, seq_err}, 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fifo_burst_reader
`default_nettype wire
